// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_pkg
// Purpose  : Shared types and width helpers for the parametrised SRAM controller
// Revision : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int SRAM_DW = 16;

  // Derived widths depend on the instance's DATA_W, so they are exposed as helpers.
  function automatic int beats_of(input int data_w);
    return data_w / SRAM_DW;
  endfunction

  function automatic int off_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  localparam int DEF_DATA_W = 32;
  localparam int DEF_BEATS  = DEF_DATA_W / SRAM_DW;
  localparam int DEF_OFF_W  = $clog2(DEF_DATA_W / 8);

endpackage
`default_nettype wire

// File: rtl/sram_addr_xlate.sv
`default_nettype none
// ============================================================================
// Module   : sram_addr_xlate
// Purpose  : CPU byte address -> SRAM word base, with range/alignment error flag
// Revision : 1.0 - initial release
// ============================================================================
module sram_addr_xlate
  import sram_ctrl_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                SRAM_AW   = 18,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 1024
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [SRAM_AW-1:0] word_base,
  output logic               addr_err
);

  localparam int BEATS = beats_of(DATA_W);
  localparam int OFF_W = off_w_of(DATA_W);

  logic [ADDR_W-1:0] w_off;

  always_comb begin
    w_off     = addr - BASE_ADDR;
    word_base = SRAM_AW'((w_off >> OFF_W) * ADDR_W'(BEATS));
    addr_err  = (addr < BASE_ADDR) || (addr[OFF_W-1:0] != '0);
  end

endmodule
`default_nettype wire

// File: rtl/sram_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_param
// Purpose  : MEM-stage controller splitting a DATA_W access into 16-bit SRAM beats
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl_param
  import sram_ctrl_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                SRAM_AW   = 18,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 1024,
  parameter int                WAIT_CYC  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic                  err,
  inout  wire  [SRAM_DW-1:0]    sram_dq,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic                  sram_we_n,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);

  localparam int BEATS  = beats_of(DATA_W);
  localparam int BE_W   = DATA_W / 8;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TC_W   = $clog2(WAIT_CYC + 1);

  localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [TC_W-1:0]   C_LAST_TCNT = TC_W'(WAIT_CYC);

  state_t              r_state, w_state_nx;
  logic                r_wr;
  logic [SRAM_AW-1:0]  r_base;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic [BEAT_W-1:0]   r_beat, w_beat_nx;
  logic [TC_W-1:0]     r_tcnt, w_tcnt_nx;
  logic [DATA_W-1:0]   r_rbuf, w_rbuf_nx;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [SRAM_AW-1:0]  r_sram_addr, w_saddr_nx;
  logic                r_we_n, r_ce_n, r_oe_n, r_ub_n, r_lb_n;
  logic                w_we_n_nx, w_ce_n_nx, w_oe_n_nx, w_ub_n_nx, w_lb_n_nx;

  logic                w_req, w_accept, w_cap, w_cap_last;
  logic                w_wr_nx, w_in_acc;
  logic [BE_W-1:0]     w_be_nx;
  logic [SRAM_AW-1:0]  w_base_nx;
  logic [1:0]          w_pair;
  logic [SRAM_AW-1:0]  w_xl_base;
  logic                w_xl_err;

  assign w_req    = wr_en | rd_en;
  assign w_accept = (r_state == IDLE) && w_req;

  sram_addr_xlate #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .SRAM_AW   (SRAM_AW),
    .BASE_ADDR (BASE_ADDR)
  ) u_xlate (
    .addr      (addr),
    .word_base (w_xl_base),
    .addr_err  (w_xl_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_beat_nx  = r_beat;
    w_tcnt_nx  = r_tcnt;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_beat_nx  = '0;
          w_tcnt_nx  = '0;
          w_state_nx = w_xl_err ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (r_tcnt == C_LAST_TCNT) begin
          w_tcnt_nx = '0;
          if (r_beat == C_LAST_BEAT) w_state_nx = DONE;
          else                       w_beat_nx  = r_beat + 1'b1;
        end else begin
          w_tcnt_nx = r_tcnt + 1'b1;
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Strobes are registered, so they are computed from next-cycle state and from
  // the values that will be latched on the accepting edge.
  always_comb begin
    w_wr_nx    = w_accept ? wr_en     : r_wr;
    w_be_nx    = w_accept ? be        : r_be;
    w_base_nx  = w_accept ? w_xl_base : r_base;
    w_in_acc   = (w_state_nx == ACCESS);
    w_pair     = w_be_nx[{w_beat_nx, 1'b0} +: 2];
    w_ce_n_nx  = ~w_in_acc;
    w_oe_n_nx  = ~(w_in_acc & ~w_wr_nx);
    w_we_n_nx  = ~(w_in_acc & w_wr_nx & (w_tcnt_nx < C_LAST_TCNT) & (|w_pair));
    w_ub_n_nx  = ~(w_in_acc & (~w_wr_nx | w_pair[1]));
    w_lb_n_nx  = ~(w_in_acc & (~w_wr_nx | w_pair[0]));
    w_saddr_nx = w_in_acc ? (w_base_nx + SRAM_AW'(w_beat_nx)) : r_sram_addr;
  end

  // Read slices assemble in a shadow buffer so rdata only changes on completion.
  always_comb begin
    w_cap      = (r_state == ACCESS) && !r_wr && (r_tcnt == C_LAST_TCNT);
    w_cap_last = w_cap && (r_beat == C_LAST_BEAT);
    w_rbuf_nx  = r_rbuf;
    if (w_cap) w_rbuf_nx[{r_beat, 4'b0000} +: SRAM_DW] = sram_dq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr        <= 1'b0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_beat      <= '0;
      r_tcnt      <= '0;
      r_rbuf      <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_sram_addr <= '0;
      r_we_n      <= 1'b1;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_lb_n      <= 1'b1;
    end else begin
      if (w_accept) begin
        r_wr    <= wr_en;
        r_base  <= w_xl_base;
        r_wdata <= wdata;
        r_be    <= be;
        r_err   <= w_xl_err;
        if (w_xl_err && !wr_en) r_rdata <= '0;
      end
      r_beat      <= w_beat_nx;
      r_tcnt      <= w_tcnt_nx;
      r_rbuf      <= w_rbuf_nx;
      if (w_cap_last) r_rdata <= w_rbuf_nx;
      r_sram_addr <= w_saddr_nx;
      r_we_n      <= w_we_n_nx;
      r_ce_n      <= w_ce_n_nx;
      r_oe_n      <= w_oe_n_nx;
      r_ub_n      <= w_ub_n_nx;
      r_lb_n      <= w_lb_n_nx;
    end
  end

  // rst in the enable releases the bus in the same instant reset rises.
  assign sram_dq = ((r_state == ACCESS) && r_wr && !rst)
                   ? r_wdata[{r_beat, 4'b0000} +: SRAM_DW]
                   : {SRAM_DW{1'bz}};

  assign ready     = ((r_state == IDLE) && !w_req) || (r_state == DONE);
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign sram_addr = r_sram_addr;
  assign sram_we_n = r_we_n;
  assign sram_ce_n = r_ce_n;
  assign sram_oe_n = r_oe_n;
  assign sram_ub_n = r_ub_n;
  assign sram_lb_n = r_lb_n;

endmodule
`default_nettype wire

// File: doc/sram_ctrl_param.md
Name: sram_ctrl_param

Overview:
Parametrised successor to the MEM-stage SRAM controller. It maps one DATA_W-bit CPU access onto BEATS = DATA_W/16 consecutive 16-bit SRAM words, with programmable wait states, byte enables, a base-address offset and error signalling. It sits between the MEM stage and the off-chip 16-bit SRAM. `ready` stalls the pipeline while an access is in flight.

Parameters:
DATA_W, 32, CPU data width; multiple of 16, at least 16
ADDR_W, 32, CPU address width
SRAM_AW, 18, SRAM word-address width
BASE_ADDR, 1024, CPU byte address that maps to SRAM word 0
WAIT_CYC, 1, extra cycles per beat; at least 1; beat length T = WAIT_CYC+1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  write request; held until ready
rd_en  in  1  read request; held until ready
addr  in  ADDR_W  CPU byte address
wdata  in  DATA_W  write data
be  in  DATA_W/8  byte enables (write only)
rdata  out  DATA_W  read data; valid when ready=1 after a read
ready  out  1  access complete / idle
err  out  1  address error; qualifies ready
sram_dq  inout  16  SRAM data bus
sram_addr  out  SRAM_AW  SRAM word address
sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active-low

Behaviour:
- Reset values: state=IDLE, rdata=0, err=0, sram_addr=0, all strobes=1, sram_dq=Z.
- Reset mid-access aborts immediately and asynchronously: we_n goes to 1 and dq is released in the same instant. No partial ready is issued.
- All SRAM outputs come from flops, except the dq tri-state, which is enabled only in write ACCESS.
- req = wr_en | rd_en. If both are asserted, the access is a write.
- ready = (IDLE & ~req) | DONE.
- FSM IDLE:
  - On req, latch op, addr, wdata and be.
  - If addr < BASE_ADDR, or addr is not aligned to DATA_W/8 bytes, set err and go to DONE. No SRAM strobes toggle.
  - Otherwise go to ACCESS with beat=0 and tcnt=0.
- Word base = ((addr − BASE_ADDR) >> log2(DATA_W/8)) × BEATS, truncated to SRAM_AW. Beat k uses sram_addr = base + k, modulo 2^SRAM_AW.
- FSM ACCESS: each beat lasts T cycles.
  - ce_n=0 throughout ACCESS.
  - Read: oe_n=0, ub_n=lb_n=0, dq=Z. On the last cycle of beat k, rdata[16k+15:16k] ← sram_dq.
  - Write: oe_n=1; dq drives wdata[16k+15:16k] for all T cycles.
  - Write strobes: ub_n=~be[2k+1], lb_n=~be[2k]. we_n=0 in cycles 0..WAIT_CYC−1 of the beat and 1 in the last cycle (data/address hold).
  - If be[2k+1:2k]=00, we_n stays 1, but the beat still consumes T cycles (fixed latency).
  - After the last beat, go to DONE.
- FSM DONE: ready=1 for exactly one cycle. Strobes return to 1, dq=Z. err holds its value. Next state is IDLE.
  - A request still held in the next cycle is a new access.
- err clears on the next accepted request.
- rdata holds its value until the next read completes. A read with err sets rdata=0.
- Latency: the request is seen in cycle 0; ready is asserted in cycle 1 + BEATS×T (default 5). An error access gets ready in cycle 1.
- Request changes while busy are ignored; latched values are used.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum {IDLE, ACCESS, DONE}
  - SRAM_DW=16
  - BEATS and the byte-offset-width localparams, via clog2
- Sub-module sram_addr_xlate is purely combinational and is used in IDLE only. It performs the base subtraction, alignment/range check and word-base computation; its outputs are the word base and the error flag.
- FSM and beat/tcnt counters stay in the top level.

Test Plan:
1. Default parameters. Write addr=1032, wdata=0xDEADBEEF, be=0xF. Required:
   - beat0: sram_addr=4, dq=0xBEEF, we_n low 1 cycle
   - beat1: sram_addr=5, dq=0xDEAD
   - ready in cycle 5
   Then read 1032 → rdata=0xDEADBEEF, ready in cycle 5, we_n never low.
2. Byte enables. Preload 1036 with 0xAABBCCDD, then write 0x11223344 with be=0x6. Required:
   - beat0: ub_n=0, lb_n=1
   - beat1: ub_n=1, lb_n=0
   Readback gives 0xAA2233DD.
3. Errors:
   - Read addr=1000 → err=1 and ready in cycle 1, ce_n stays 1, rdata=0.
   - Write addr=1026 → err=1, we_n never low.
   - Next valid access clears err.
4. Assert rd_en and wr_en together with addr=1040 → a write is performed (oe_n=1, we_n pulses). A subsequent read returns the written data.
5. Assert rst during beat0 of a write → we_n=1 and dq=Z asynchronously. After release with no request: state IDLE, ready=1, SRAM contents at word 6/7 not corrupted beyond beat0.
6. DATA_W=64, WAIT_CYC=3, read addr=1048 → BEATS=4, sram_addr 12..15, each held 4 cycles, ready in cycle 17, all four 16-bit slices assembled in order.
